// File: rtl/led_scanner_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings, direction
// values and the width helper for the position register.
package led_scanner_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BOUNCE = 2'd0;
    localparam mode_t MODE_ROT_L  = 2'd1;
    localparam mode_t MODE_ROT_R  = 2'd2;
    localparam mode_t MODE_BAR    = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int unsigned pos_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler that emits a single-cycle step tick every
// 2^(PRESC_W - iSPEED) enabled cycles.
module led_prescaler
    import led_scanner_pkg::*;
#(
    parameter int unsigned PRESC_W = 19
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iEN,
    input  logic [1:0] iSPEED,
    output logic       oTICK_INT
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic [PRESC_W-1:0] mask;

    // Low bits that must all be ones for a tick; narrower at higher speeds.
    always_comb begin
        mask = {PRESC_W{1'b1}} >> iSPEED;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (iEN) begin
            cnt_d = cnt_q + PRESC_W'(1);
        end
    end

    always_comb begin
        oTICK_INT = iEN & ((cnt_q & mask) == mask);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_scanner.sv
// LED pattern engine: bounce, rotate left/right and bar-graph modes with a
// registered LED bank and a step pulse aligned to each new pattern.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int unsigned N_LED   = 8,
    parameter int unsigned PRESC_W = 19
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iEN,
    input  logic [1:0]       iSPEED,
    input  logic [1:0]       iMODE,
    output logic [N_LED-1:0] oLED,
    output logic             oTICK
);

    localparam int unsigned PW = pos_width(N_LED);

    localparam logic [PW-1:0] POS_ZERO = '0;
    localparam logic [PW-1:0] POS_ONE  = PW'(1);
    localparam logic [PW-1:0] POS_MAX  = PW'(N_LED - 1);
    localparam logic [PW-1:0] POS_TURN = PW'(N_LED - 2);

    localparam logic [N_LED-1:0] LED_ONE  = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] LED_ONES = {N_LED{1'b1}};

    logic          tick;
    logic [PW-1:0] pos_q;
    logic [PW-1:0] pos_d;
    logic          dir_q;
    logic          dir_d;
    mode_t         mode_q;
    mode_t         mode_d;
    logic [N_LED-1:0] led_d;
    logic [N_LED-1:0] dot_map;
    logic [N_LED-1:0] bar_map;

    led_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iEN       (iEN),
        .iSPEED    (iSPEED),
        .oTICK_INT (tick)
    );

    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (tick) begin
            if (iMODE != mode_q) begin
                // A mode switch restarts the pattern and takes no step.
                mode_d = iMODE;
                pos_d  = POS_ZERO;
                dir_d  = DIR_UP;
            end else begin
                unique case (mode_q)
                    MODE_ROT_L: begin
                        pos_d = (pos_q == POS_MAX) ? POS_ZERO : pos_q + POS_ONE;
                    end
                    MODE_ROT_R: begin
                        pos_d = (pos_q == POS_ZERO) ? POS_MAX : pos_q - POS_ONE;
                    end
                    MODE_BOUNCE, MODE_BAR: begin
                        if (dir_q == DIR_UP) begin
                            if (pos_q == POS_MAX) begin
                                dir_d = DIR_DOWN;
                                pos_d = POS_TURN;
                            end else begin
                                pos_d = pos_q + POS_ONE;
                            end
                        end else begin
                            if (pos_q == POS_ZERO) begin
                                dir_d = DIR_UP;
                                pos_d = POS_ONE;
                            end else begin
                                pos_d = pos_q - POS_ONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Bar keeps bits 0..pos; the double shift avoids overflowing pos+1.
    always_comb begin
        dot_map = LED_ONE << pos_d;
        bar_map = ~((LED_ONES << pos_d) << 1);
    end

    always_comb begin
        led_d = oLED;
        if (tick) begin
            led_d = (mode_d == MODE_BAR) ? bar_map : dot_map;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pos_q  <= POS_ZERO;
            dir_q  <= DIR_UP;
            mode_q <= MODE_BOUNCE;
            oLED   <= LED_ONE;
            oTICK  <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            oLED   <= led_d;
            oTICK  <= tick;
        end
    end

`ifndef SYNTHESIS
    a_led_nonzero: assert property (@(posedge iCLK) disable iff (!iRST_N) oLED != '0);
    a_led_onehot: assert property (@(posedge iCLK) disable iff (!iRST_N)
        (mode_q != MODE_BAR) |-> $onehot(oLED));
    a_pos_range: assert property (@(posedge iCLK) disable iff (!iRST_N) pos_q <= POS_MAX);
`endif

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner (N_LED=4, PRESC_W=4) with a step-index
// reference model compared every cycle and literal per-step expectations.
module tb_led_scanner;

    localparam int NL = 4;
    localparam int PW = 4;

    logic          iCLK   = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iEN    = 1'b0;
    logic [1:0]    iSPEED = 2'd0;
    logic [1:0]    iMODE  = 2'd0;
    logic [NL-1:0] oLED;
    logic          oTICK;

    int checks = 0;
    int errors = 0;

    always #5 iCLK = ~iCLK;

    led_scanner #(
        .N_LED   (NL),
        .PRESC_W (PW)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iEN    (iEN),
        .iSPEED (iSPEED),
        .iMODE  (iMODE),
        .oLED   (oLED),
        .oTICK  (oTICK)
    );

    // Pattern as a function of steps taken since the mode was entered.
    function automatic logic [NL-1:0] pattern(input int mode, input int k);
        int sweep;
        int kk;
        int pos;
        sweep = 2 * NL - 2;
        if (mode == 1) begin
            pos = k % NL;
        end else if (mode == 2) begin
            pos = (NL - (k % NL)) % NL;
        end else begin
            kk  = k % sweep;
            pos = (kk < NL) ? kk : sweep - kk;
        end
        if (mode == 3) begin
            return NL'((1 << (pos + 1)) - 1);
        end
        return NL'(1 << pos);
    endfunction

    int            m_cnt  = 0;
    int            m_k    = 0;
    int            m_mode = 0;
    logic [NL-1:0] m_led  = 4'b0001;
    logic          m_tick = 1'b0;
    int            m_period;
    logic          m_tk;

    always_comb begin
        m_period = (1 << PW) >> iSPEED;
        m_tk     = iEN && ((m_cnt % m_period) == (m_period - 1));
    end

    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            m_cnt  <= 0;
            m_k    <= 0;
            m_mode <= 0;
            m_led  <= pattern(0, 0);
            m_tick <= 1'b0;
        end else begin
            if (iEN) begin
                m_cnt <= (m_cnt + 1) % (1 << PW);
            end
            if (m_tk) begin
                if (int'(iMODE) != m_mode) begin
                    m_mode <= int'(iMODE);
                    m_k    <= 0;
                    m_led  <= pattern(int'(iMODE), 0);
                end else begin
                    m_k   <= m_k + 1;
                    m_led <= pattern(m_mode, m_k + 1);
                end
            end
            m_tick <= m_tk;
        end
    end

    always @(negedge iCLK) begin
        checks++;
        if (oLED !== m_led || oTICK !== m_tick) begin
            errors++;
            $display("FAIL model: oLED=%b oTICK=%b, required oLED=%b oTICK=%b at %0t",
                     oLED, oTICK, m_led, m_tick, $time);
        end
    end

    task automatic check(input string name, input logic [NL-1:0] act, input logic [NL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Wait for the next step pulse; check its spacing and the new pattern.
    task automatic wait_step(input string name, input logic [NL-1:0] exp, input int gap);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge iCLK);
            n++;
            if (oTICK) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no oTICK within %0d cycles, required one after %0d",
                     name, n, gap);
        end else begin
            check_int({name, " gap"}, n, gap);
            check(name, oLED, exp);
        end
    endtask

    logic [NL-1:0] bounce_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                      4'b0010, 4'b0001, 4'b0010};
    logic [NL-1:0] rotr_exp   [5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [NL-1:0] bar_exp    [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                      4'b0111, 4'b0011, 4'b0001};
    logic [NL-1:0] rotl_exp   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int ticks_seen;

        iRST_N = 1'b0;
        repeat (2) @(negedge iCLK);
        check("reset oLED", oLED, 4'b0001);
        check_int("reset oTICK", int'(oTICK), 0);
        iRST_N = 1'b1;
        iEN    = 1'b1;

        for (int i = 0; i < 7; i++) begin
            wait_step($sformatf("bounce step %0d", i), bounce_exp[i], 16);
        end

        iMODE  = 2'd2;
        iSPEED = 2'd2;
        for (int i = 0; i < 5; i++) begin
            wait_step($sformatf("rotr step %0d", i), rotr_exp[i], 4);
        end

        iMODE = 2'd3;
        for (int i = 0; i < 7; i++) begin
            wait_step($sformatf("bar step %0d", i), bar_exp[i], 4);
        end

        iMODE = 2'd0;
        wait_step("bounce restart", 4'b0001, 4);
        wait_step("bounce up 1", 4'b0010, 4);
        wait_step("bounce up 2", 4'b0100, 4);

        iMODE = 2'd1;
        for (int i = 0; i < 5; i++) begin
            wait_step($sformatf("rotl step %0d", i), rotl_exp[i], 4);
        end

        iSPEED = 2'd0;
        repeat (5) @(negedge iCLK);
        iEN = 1'b0;
        ticks_seen = 0;
        repeat (40) begin
            @(negedge iCLK);
            if (oTICK) ticks_seen++;
        end
        check_int("pause ticks", ticks_seen, 0);
        check("pause oLED", oLED, 4'b0001);
        check_int("pause cnt", int'(dut.u_prescaler.cnt_q), 5);
        check_int("pause pos", int'(dut.pos_q), 0);
        iEN = 1'b1;
        wait_step("resume", 4'b0010, 11);
        wait_step("rotl after resume 1", 4'b0100, 16);
        wait_step("rotl after resume 2", 4'b1000, 16);

        #2;
        iRST_N = 1'b0;
        #1;
        check("async reset oLED", oLED, 4'b0001);
        check_int("async reset oTICK", int'(oTICK), 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        wait_step("post-reset mode change", 4'b0001, 16);
        wait_step("post-reset rotl", 4'b0010, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
